// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and a sequential clear sweep.
// Optional same-cycle write/issue forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [XLEN-1:0]       wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd1,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  clear_req,
  output logic                  sweep_busy
);

  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] x [NREGS];
  logic [NREGS-1:0] busy;

  logic wr0_ok, wr1_ok, iss_ok;
  assign wr0_ok = we0 && !(ZR && (wa0 == '0));
  assign wr1_ok = we1 && !(ZR && (wa1 == '0));
  assign iss_ok = iss_valid && !(ZR && (iss_rd == '0));

  // Array, scoreboard and sweep engine; later NBAs give port 1 and issue priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) x[i] <= '0;
      busy       <= '0;
      state      <= IDLE;
      ptr        <= '0;
      sweep_busy <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (wr0_ok) begin
          x[wa0]    <= wd0;
          busy[wa0] <= 1'b0;
        end
        if (wr1_ok) begin
          x[wa1]    <= wd1;
          busy[wa1] <= 1'b0;
        end
        if (iss_ok) busy[iss_rd] <= 1'b1;
        if (clear_req) begin
          state      <= SWEEP;
          sweep_busy <= 1'b1;
          ptr        <= '0;
          busy       <= '0;
        end
      end else begin
        x[ptr] <= '0;
        ptr    <= AW'(ptr + 1'b1);
        if (ptr == AW'(NREGS - 1)) begin
          state      <= IDLE;
          sweep_busy <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[g*AW +: AW];

    always_comb begin
      d = x[a];
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      if (state == IDLE) begin
        if (we0 && (wa0 == a)) d = wd0;
        if (we1 && (wa1 == a)) d = wd1;
        // A new producer issued this cycle keeps the register marked busy.
        if (((we0 && (wa0 == a)) || (we1 && (wa1 == a))) && !(iss_valid && (iss_rd == a)))
          b = 1'b0;
      end
`endif
      if (ZR && (a == '0)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[g*XLEN +: XLEN] = d;
    assign rd_busy[g]              = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0, we1, iss_valid, clear_req;
  logic [4:0]  wa0, wa1, iss_rd;
  logic [31:0] wd0, wd1;
  logic        sweep_busy;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .clear_req(clear_req), .sweep_busy(sweep_busy)
  );

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic chk = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] act_d;
  logic        act_b;

  // Monitor: pop every expectation queued for this cycle and compare mid-cycle.
  always @(negedge clk) begin
    if (chk) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (e.kind == 0) begin
          act_d = rd_data[e.port*32 +: 32];
          act_b = rd_busy[e.port];
          if (act_d !== e.d || act_b !== e.b) begin
            bad++;
            $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                     e.tag, e.port, act_d, act_b, e.d, e.b);
          end
        end else if (sweep_busy !== e.b) begin
          bad++;
          $display("FAIL %s: got sweep_busy=%b, want %b", e.tag, sweep_busy, e.b);
        end
      end
    end
  end

  task automatic exp_rd(input string tag, input int port, input logic [4:0] a,
                        input logic [31:0] d, input logic b);
    rd_addr[port*5 +: 5] = a;
    q.push_back('{tag, 0, port, d, b});
    chk = 1'b1;
  endtask

  task automatic exp_sb(input string tag, input logic b);
    q.push_back('{tag, 1, 0, 32'h0, b});
    chk = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    chk = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0; clear_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_addr = '0;
    we0 = 1'b0; wa0 = '0; wd0 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_rd = '0; clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_rd("rst_hold", 0, 5'd0, 32'h0, 1'b0); exp_sb("rst_hold_sb", 1'b0); cyc();
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      exp_rd("rst_rd", 0, 5'(2*a), 32'h0, 1'b0);
      exp_rd("rst_rd", 1, 5'(2*a+1), 32'h0, 1'b0);
      exp_sb("rst_sb", 1'b0);
      cyc();
    end

    // Dual write to x5: port 1 wins; x0 hardwired.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h12345678;
    exp_rd("wr_same_cyc", 0, 5'd5, BYP ? 32'h12345678 : 32'h0, 1'b0); cyc();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    exp_rd("x5_port1_wins", 0, 5'd5, 32'h12345678, 1'b0);
    exp_rd("x0_wr_cyc", 1, 5'd0, 32'h0, 1'b0); cyc();
    exp_rd("x0_hardwired", 0, 5'd0, 32'h0, 1'b0); cyc();

    // Busy scoreboard.
    iss_valid = 1'b1; iss_rd = 5'd7;
    exp_rd("iss_cyc", 0, 5'd7, 32'h0, 1'b0); cyc();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5;
    exp_rd("busy_set", 0, 5'd7, BYP ? 32'hA5 : 32'h0, BYP ? 1'b0 : 1'b1); cyc();
    exp_rd("busy_clr", 0, 5'd7, 32'hA5, 1'b0); cyc();
    iss_valid = 1'b1; iss_rd = 5'd7; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h77;
    exp_rd("iss_wr_cyc", 0, 5'd7, BYP ? 32'h77 : 32'hA5, 1'b0); cyc();
    iss_valid = 1'b1; iss_rd = 5'd0;
    exp_rd("iss_wins", 0, 5'd7, 32'h77, 1'b1); cyc();
    exp_rd("x0_never_busy", 0, 5'd0, 32'h0, 1'b0); cyc();

    // Same-cycle visibility of x3.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
    exp_rd("byp_x3", 0, 5'd3, BYP ? 32'h55 : 32'h0, 1'b0); cyc();
    exp_rd("x3_next", 0, 5'd3, 32'h55, 1'b0); cyc();

    // Fill then sweep.
    for (int r = 0; r < 32; r += 2) begin
      we0 = 1'b1; wa0 = 5'(r);   wd0 = 32'h100 + 32'(r);
      we1 = 1'b1; wa1 = 5'(r+1); wd1 = 32'h101 + 32'(r);
      cyc();
    end
    iss_valid = 1'b1; iss_rd = 5'd9; cyc();
    clear_req = 1'b1;
    exp_rd("pre_clear_busy", 0, 5'd9, 32'h109, 1'b1); exp_sb("clr_cyc_sb", 1'b0); cyc();
    for (int k = 0; k < 32; k++) begin
      exp_sb("sweep_sb", 1'b1);
      exp_rd("sweep_cur", 0, 5'(k), (k == 0) ? 32'h0 : 32'h100 + 32'(k), 1'b0);
      if (k < 3) exp_rd("sweep_tail", 1, 5'd31, 32'h11F, 1'b0);
      else       exp_rd("sweep_done", 1, 5'd2, 32'h0, 1'b0);
      if (k == 10) begin
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hBAD; iss_valid = 1'b1; iss_rd = 5'd2;
        clear_req = 1'b1;
      end
      cyc();
    end
    exp_sb("sweep_end", 1'b0);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99; cyc();
    for (int a = 0; a < 16; a++) begin
      exp_rd("post_sweep", 0, 5'(2*a), 32'h0, 1'b0);
      exp_rd("post_sweep", 1, 5'(2*a+1), (2*a+1 == 9) ? 32'h99 : 32'h0, 1'b0);
      cyc();
    end

    // Reset in the middle of a sweep.
    we0 = 1'b1; wa0 = 5'd15; wd0 = 32'h1515; cyc();
    clear_req = 1'b1; cyc();
    for (int k = 0; k < 10; k++) begin
      exp_sb("sweep2_sb", 1'b1);
      if (k == 9) exp_rd("pre_rst_x15", 0, 5'd15, 32'h1515, 1'b0);
      cyc();
    end
    rst_n = 1'b0;
    exp_rd("rst_mid_x15", 0, 5'd15, 32'h0, 1'b0);
    exp_rd("rst_mid_x9", 1, 5'd9, 32'h0, 1'b0);
    exp_sb("rst_mid_sb", 1'b0); cyc();
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66;
    exp_sb("post_rst_sb", 1'b0); cyc();
    exp_rd("post_rst_wr", 0, 5'd6, 32'h66, 1'b0);
    exp_rd("post_rst_x15", 1, 5'd15, 32'h0, 1'b0);
    exp_sb("post_rst_idle", 1'b0); cyc();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard and a sequential clear engine, the successor to the single-write, two-read `regfile` in the core datapath. It provides NRD combinational read ports and two clocked write ports. A busy bit per register tracks in-flight producers for the hazard unit. A `clear_req` command zeroes the whole array one entry per cycle without a reset.

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of registers; power of two, 4..64. `AW = $clog2(NREGS)` is a localparam.
- `NRD`, 2, number of read ports, 1..4.
- `ZERO_REG`, 1, when 1, register 0 is hardwired to zero and never busy.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rd_addr`  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- `rd_data`  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- `rd_busy`  out  NRD  busy bit of each addressed register.
- `we0`, `wa0`, `wd0`  in  1/AW/XLEN  write port 0: enable, address, data.
- `we1`, `wa1`, `wd1`  in  1/AW/XLEN  write port 1: enable, address, data.
- `iss_valid`, `iss_rd`  in  1/AW  issue: mark register `iss_rd` busy.
- `clear_req`  in  1  start a full-array clear sweep.
- `sweep_busy`  out  1  high while the sweep is in progress.

## Operation
- Storage is an array of NREGS x XLEN flops, plus a `busy[NREGS]` vector.
- Reads are combinational: `rd_data[i] = x[rd_addr[i]]` and `rd_busy[i] = busy[rd_addr[i]]`.
- If ZERO_REG=1, address 0 always reads 0 with busy 0.
- Writes commit at the rising edge.
  - If ZERO_REG=1, writes to address 0 are dropped.
  - If `we0` and `we1` target the same address, port 1 wins.
- Each write clears the busy bit of its address.
- `iss_valid` sets `busy[iss_rd]`. If the same edge also writes `iss_rd`, the set wins: the data is written and busy ends at 1, because the new producer supersedes the old one.
- Sweep FSM:
  - States are IDLE and SWEEP; `ptr` is a counter of AW bits.
  - IDLE to SWEEP on `clear_req`: `ptr` loads 0, and all busy bits clear on that same edge.
  - In SWEEP, each edge sets `x[ptr] <= 0` and increments `ptr`.
  - SWEEP to IDLE on the edge that clears entry NREGS-1; `ptr` wraps to 0.
  - In SWEEP, `we0`, `we1`, `iss_valid` and `clear_req` are ignored. Reads remain live and return partially cleared contents.
- Reset (`rst_n`=0, at any time including mid-sweep):
  - All registers are 0, all busy bits 0, FSM is IDLE, `ptr` is 0.
  - `sweep_busy` is 0. `rd_data` and `rd_busy` reflect the cleared array (all 0).

## Timing
- Read latency is 0 cycles (combinational from the address).
- Write-to-read visibility is 1 edge; same-cycle forwarding is covered under Configuration.
- Busy set and clear take effect 1 edge after issue or write.
- `sweep_busy` rises the cycle after the `clear_req` edge. It stays high for exactly NREGS cycles and falls after the final clear edge.
- The first accepted write after a sweep is the one presented the cycle `sweep_busy` is 0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Read ports forward same-cycle write data: port 1 has priority over port 0, then the array.
  - `rd_busy` reads 0 when a write to that address is presented, unless `iss_valid` targets the same address that cycle.
  - Forwarding is suppressed during SWEEP and for address 0 when ZERO_REG=1.
- Not defined: reads return pre-edge array contents only. No combinational path exists from the write or issue ports to the read outputs.

## Test plan
- Reset then read all addresses -> `rd_data` is 0 and `rd_busy` is 0 everywhere; `sweep_busy` is 0.
- `we0` x5=0xDEADBEEF and `we1` x5=0x12345678 on the same edge -> next cycle x5 reads 0x12345678. A write of 0xFFFFFFFF to x0 -> x0 reads 0.
- `iss_valid` x7, then the next cycle write x7=0xA5 -> `rd_busy` is 1 for one cycle, then 0 with data 0xA5. Issue plus write of x7 on the same edge -> busy remains 1.
- With the macro: write x3=0x55 while reading x3 -> `rd_data` is 0x55 in the same cycle. Without the macro: old value this cycle, 0x55 the next cycle.
- Fill all registers with nonzero values, then pulse `clear_req` -> `sweep_busy` is high for exactly 32 cycles and all registers read 0. A `we0` issued mid-sweep is dropped.
- Assert `rst_n`=0 at sweep cycle 10 -> outputs go to 0 immediately. After release, the FSM is IDLE and writes are accepted on the first edge.
